// File: rtl/frame_sequencer.sv
// frame_sequencer
//   Per-frame controller for the battle-front finder. Each accepted game-frame
//   tick runs one finder transaction (Start, wait for Done, latch results),
//   then issues the attack strobes and the movement strobe, and finally
//   acknowledges the finder so it can re-arm. It also counts frames and
//   dropped ticks, and flags a finder that never answers.
//
// Ports
//   clk                 system clock
//   rst                 asynchronous, active-low reset
//   frameTick           one-cycle pulse per game frame
//   pause               level; ticks ignored (and not counted) while high
//   bfDone              finder Done
//   friendlyFront       finder result, 9-bit front position
//   enemyFront          finder result, 9-bit front position
//   unitDamageSelect    finder result, bit4 = tower
//   enemyDamageSelect   finder result, bit4 = tower
//   bfStart             finder Start, one cycle
//   bfAck               finder Ack, held while acknowledging
//   hitUnit/hitUnitSel  attack strobe on a friendly unit and its index
//   hitEnemy/hitEnemySel attack strobe on an enemy unit and its index
//   moveEn              one-cycle movement strobe
//   moveFriendlyLimit   latched friendlyFront
//   moveEnemyLimit      latched enemyFront
//   busy                high whenever a frame is in progress
//   frameCount          accepted frames, wraps
//   overrunCount        dropped ticks, saturates at 255
//   timeoutErr          sticky finder-timeout flag
module frame_sequencer #(
    parameter int ATTACK_PERIOD = 4,
    parameter int BF_TIMEOUT    = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frameTick,
    input  logic       pause,
    input  logic       bfDone,
    input  logic [8:0] friendlyFront,
    input  logic [8:0] enemyFront,
    input  logic [4:0] unitDamageSelect,
    input  logic [4:0] enemyDamageSelect,
    output logic       bfStart,
    output logic       bfAck,
    output logic       hitUnit,
    output logic [4:0] hitUnitSel,
    output logic       hitEnemy,
    output logic [4:0] hitEnemySel,
    output logic       moveEn,
    output logic [8:0] moveFriendlyLimit,
    output logic [8:0] moveEnemyLimit,
    output logic       busy,
    output logic [15:0] frameCount,
    output logic [7:0] overrunCount,
    output logic       timeoutErr
);

    typedef enum logic [5:0] {
        IDLE   = 6'b000001,
        START  = 6'b000010,
        WAIT   = 6'b000100,
        ATTACK = 6'b001000,
        MOVE   = 6'b010000,
        ACK    = 6'b100000
    } state_t;

    localparam logic [7:0] ATK_LAST = 8'(ATTACK_PERIOD - 1);
    localparam logic [7:0] TMO_LAST = 8'(BF_TIMEOUT - 1);

    state_t     state;
    state_t     stateNext;

    logic [7:0] atkCnt;
    logic [7:0] tmo;

    logic [8:0] friendlyHold;
    logic [8:0] enemyHold;
    logic [4:0] unitSelHold;
    logic [4:0] enemySelHold;

    logic       tickValid;
    logic       contact;
    logic       atkWrap;
    logic       tmoHit;

    // Saturating increment for the dropped-tick counter.
    function automatic logic [7:0] satInc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign tickValid = frameTick & ~pause;
    // Fronts are plain positions: compare unsigned.
    assign contact   = (friendlyHold <= enemyHold);
    assign atkWrap   = (atkCnt == ATK_LAST);
    assign tmoHit    = (tmo == TMO_LAST);

    assign busy              = (state != IDLE);
    assign hitUnitSel        = unitSelHold;
    assign hitEnemySel       = enemySelHold;
    assign moveFriendlyLimit = friendlyHold;
    assign moveEnemyLimit    = enemyHold;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        stateNext = state;
        bfStart   = 1'b0;
        bfAck     = 1'b0;
        hitUnit   = 1'b0;
        hitEnemy  = 1'b0;
        moveEn    = 1'b0;
        unique case (state)
            IDLE: begin
                if (tickValid) begin
                    stateNext = START;
                end
            end
            START: begin
                bfStart   = 1'b1;
                stateNext = WAIT;
            end
            WAIT: begin
                if (bfDone) begin
                    stateNext = ATTACK;
                end else if (tmoHit) begin
                    // Finder never answered: skip attack and move, go straight to Ack.
                    stateNext = ACK;
                end
            end
            ATTACK: begin
                if (atkWrap && contact) begin
                    hitUnit  = 1'b1;
                    hitEnemy = 1'b1;
                end
                stateNext = MOVE;
            end
            MOVE: begin
                moveEn    = 1'b1;
                stateNext = ACK;
            end
            ACK: begin
                bfAck = 1'b1;
                if (!bfDone) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Frame-level counters, timeout timer and attack cadence.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            atkCnt       <= 8'd0;
            tmo          <= 8'd0;
            frameCount   <= 16'd0;
            overrunCount <= 8'd0;
            timeoutErr   <= 1'b0;
        end else begin
            if (tickValid) begin
                if (state == IDLE) begin
                    frameCount <= frameCount + 16'd1;
                end else begin
                    // Tick arriving mid-frame (including the ACK exit cycle) is dropped.
                    overrunCount <= satInc8(overrunCount);
                end
            end
            if (state == START) begin
                tmo <= 8'd0;
            end else if (state == WAIT) begin
                tmo <= tmo + 8'd1;
            end
            if (state == WAIT && !bfDone && tmoHit) begin
                timeoutErr <= 1'b1;
            end
            if (state == ATTACK) begin
                atkCnt <= atkWrap ? 8'd0 : atkCnt + 8'd1;
            end
        end
    end

    // Finder result holding registers; untouched on a timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            friendlyHold <= 9'd0;
            enemyHold    <= 9'd0;
            unitSelHold  <= 5'd0;
            enemySelHold <= 5'd0;
        end else if (state == WAIT && bfDone) begin
            friendlyHold <= friendlyFront;
            enemyHold    <= enemyFront;
            unitSelHold  <= unitDamageSelect;
            enemySelHold <= enemyDamageSelect;
        end
    end

endmodule

// File: tb/tb_frame_sequencer.sv
// Testbench for frame_sequencer: directed frames with a finder model; hit and
// move strobes are checked by a monitor against expectations queued by the
// stimulus process.
module tb_frame_sequencer;
    localparam int ATTACK_PERIOD = 4;
    localparam int BF_TIMEOUT    = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frameTick = 1'b0;
    logic       pause = 1'b0;
    logic       bfDone = 1'b0;
    logic [8:0] friendlyFront = 9'd0;
    logic [8:0] enemyFront = 9'd0;
    logic [4:0] unitDamageSelect = 5'd0;
    logic [4:0] enemyDamageSelect = 5'd0;
    logic       bfStart, bfAck, hitUnit, hitEnemy, moveEn, busy, timeoutErr;
    logic [4:0] hitUnitSel, hitEnemySel;
    logic [8:0] moveFriendlyLimit, moveEnemyLimit;
    logic [15:0] frameCount;
    logic [7:0] overrunCount;

    frame_sequencer #(.ATTACK_PERIOD(ATTACK_PERIOD), .BF_TIMEOUT(BF_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .frameTick(frameTick), .pause(pause), .bfDone(bfDone),
        .friendlyFront(friendlyFront), .enemyFront(enemyFront),
        .unitDamageSelect(unitDamageSelect), .enemyDamageSelect(enemyDamageSelect),
        .bfStart(bfStart), .bfAck(bfAck), .hitUnit(hitUnit), .hitUnitSel(hitUnitSel),
        .hitEnemy(hitEnemy), .hitEnemySel(hitEnemySel), .moveEn(moveEn),
        .moveFriendlyLimit(moveFriendlyLimit), .moveEnemyLimit(moveEnemyLimit),
        .busy(busy), .frameCount(frameCount), .overrunCount(overrunCount),
        .timeoutErr(timeoutErr)
    );

    typedef struct {
        logic [17:0] data;
        int          cyc;
    } exp_t;

    exp_t hitQ[$];
    exp_t moveQ[$];
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    int   expFrames = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the head of its expectation queue.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (hitUnit || hitEnemy) begin
                if (hitQ.size() == 0) begin
                    check("hit unexpected strobe", {30'd0, hitUnit, hitEnemy}, 32'd0);
                end else begin
                    e = hitQ.pop_front();
                    check("hit both strobes", {30'd0, hitUnit, hitEnemy}, 32'd3);
                    check("hit selects", {22'd0, hitUnitSel, hitEnemySel}, {22'd0, e.data[9:0]});
                    check("hit cycle", cyc, e.cyc);
                end
            end
            if (moveEn) begin
                if (moveQ.size() == 0) begin
                    check("move unexpected strobe", {31'd0, moveEn}, 32'd0);
                end else begin
                    e = moveQ.pop_front();
                    check("move limits", {14'd0, moveFriendlyLimit, moveEnemyLimit}, {14'd0, e.data});
                    check("move cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic tickPulse();
        @(posedge clk); #1 frameTick = 1'b1;
        @(posedge clk); #1 frameTick = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    // One frame with a standard finder answering 'delay' cycles after Start.
    // With holdAck the finder keeps Done high and the task returns in ACK.
    task automatic runFrame(input logic [8:0] ff, input logic [8:0] ef,
                            input logic [4:0] us, input logic [4:0] es,
                            input int delay, input bit expHit, input bit holdAck);
        int k;
        int n;
        @(posedge clk); #1 frameTick = 1'b1;
        @(posedge clk); #1 frameTick = 1'b0;
        expFrames++;
        @(negedge clk);
        check("bfStart pulse", {31'd0, bfStart}, 32'd1);
        repeat (delay) @(posedge clk);
        #1;
        friendlyFront = ff; enemyFront = ef;
        unitDamageSelect = us; enemyDamageSelect = es;
        bfDone = 1'b1;
        k = cyc;
        if (expHit) hitQ.push_back('{data: {8'd0, us, es}, cyc: k + 1});
        moveQ.push_back('{data: {ff, ef}, cyc: k + 2});
        @(negedge clk);
        check("bfStart low in WAIT", {30'd0, bfStart, busy}, 32'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bfAck && n < 20);
        check("bfAck first cycle", cyc, k + 3);
        check("frameCount", {16'd0, frameCount}, expFrames);
        if (holdAck) return;
        @(posedge clk); #1;
        bfDone = 1'b0;
        friendlyFront = 9'h1AA; enemyFront = 9'h055;
        unitDamageSelect = 5'h1E; enemyDamageSelect = 5'h01;
        @(negedge clk);
        check("bfAck second cycle", {31'd0, bfAck}, 32'd1);
        @(negedge clk);
        check("idle after ack", {30'd0, busy, bfAck}, 32'd0);
        check("limits held", {14'd0, moveFriendlyLimit, moveEnemyLimit}, {14'd0, ff, ef});
        check("selects held", {22'd0, hitUnitSel, hitEnemySel}, {22'd0, us, es});
    endtask

    initial begin
        int t0;
        int n;
        #2 rst = 1'b0;
        #1;
        check("reset strobes", {26'd0, bfStart, bfAck, hitUnit, hitEnemy, moveEn, busy}, 32'd0);
        check("reset counters", {frameCount, overrunCount, 7'd0, timeoutErr}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Attack cadence: contact in frames 1-8, hits only in frames 4 and 8.
        runFrame(9'd100, 9'd120, 5'd3,  5'd5,  1, 0, 0);
        runFrame(9'd10,  9'd11,  5'd1,  5'd2,  2, 0, 0);
        runFrame(9'd0,   9'd511, 5'd7,  5'd8,  3, 0, 0);
        runFrame(9'd100, 9'd120, 5'd3,  5'd5,  1, 1, 0);
        runFrame(9'd50,  9'd60,  5'd9,  5'd10, 1, 0, 0);
        runFrame(9'd5,   9'd5,   5'd11, 5'd12, 2, 0, 0);
        runFrame(9'd300, 9'd301, 5'd13, 5'd14, 1, 0, 0);
        runFrame(9'd255, 9'd400, 5'h10, 5'h0A, 2, 1, 0);
        // No contact: move still issued, hit suppressed even on the attack frame.
        runFrame(9'd200, 9'd150, 5'd1,  5'd2,  1, 0, 0);
        runFrame(9'd200, 9'd150, 5'd2,  5'd3,  2, 0, 0);
        runFrame(9'd200, 9'd150, 5'd3,  5'd4,  1, 0, 0);
        runFrame(9'd200, 9'd150, 5'd4,  5'd6,  1, 0, 0);
        runFrame(9'd150, 9'd149, 5'd5,  5'd7,  1, 0, 0);
        runFrame(9'd20,  9'd30,  5'd6,  5'd8,  2, 0, 0);
        runFrame(9'd21,  9'd31,  5'd7,  5'd9,  1, 0, 0);
        // Equal fronts count as contact; tower selects pass through.
        runFrame(9'd150, 9'd150, 5'h13, 5'h1F, 1, 1, 0);
        check("no timeout yet", {31'd0, timeoutErr}, 32'd0);

        // Finder timeout.
        @(posedge clk); #1 frameTick = 1'b1; t0 = cyc;
        @(posedge clk); #1 frameTick = 1'b0;
        expFrames++;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bfAck && n < 60);
        check("timeout ack latency", cyc - (t0 + 2), BF_TIMEOUT);
        check("timeoutErr set", {31'd0, timeoutErr}, 32'd1);
        check("timeout limits kept", {14'd0, moveFriendlyLimit, moveEnemyLimit}, {14'd0, 9'd150, 9'd150});
        check("timeout selects kept", {22'd0, hitUnitSel, hitEnemySel}, {22'd0, 5'h13, 5'h1F});
        @(negedge clk);
        check("timeout ack one cycle", {31'd0, busy}, 32'd0);
        check("timeout frameCount", {16'd0, frameCount}, expFrames);

        runFrame(9'd40, 9'd80, 5'd2, 5'd4, 2, 0, 0);
        check("timeoutErr sticky", {31'd0, timeoutErr}, 32'd1);

        // Pause while idle: no frame starts, nothing counted.
        pause = 1'b1;
        repeat (3) tickPulse();
        pause = 1'b0;
        @(negedge clk);
        check("pause idle busy", {31'd0, busy}, 32'd0);
        check("pause idle frames", {16'd0, frameCount}, expFrames);
        check("pause idle overrun", {24'd0, overrunCount}, 32'd0);

        // Overruns while the frame is held in ACK.
        runFrame(9'd60, 9'd70, 5'd1, 5'd1, 1, 0, 1);
        pause = 1'b1;
        repeat (3) tickPulse();
        pause = 1'b0;
        @(negedge clk);
        check("pause in frame overrun", {24'd0, overrunCount}, 32'd0);
        check("pause does not stall", {31'd0, bfAck}, 32'd1);
        repeat (10) tickPulse();
        @(negedge clk);
        check("overrun count 10", {24'd0, overrunCount}, 32'd10);
        // Tick on the cycle ACK exits is still dropped.
        @(posedge clk); #1 bfDone = 1'b0; frameTick = 1'b1;
        @(posedge clk); #1 frameTick = 1'b0;
        @(negedge clk);
        check("exit tick overrun", {24'd0, overrunCount}, 32'd11);
        check("exit tick busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("exit tick no start", {30'd0, busy, bfStart}, 32'd0);
        check("exit tick frames", {16'd0, frameCount}, expFrames);

        // Saturation.
        runFrame(9'd61, 9'd71, 5'd2, 5'd2, 1, 0, 1);
        repeat (244) tickPulse();
        @(negedge clk);
        check("overrun reaches 255", {24'd0, overrunCount}, 32'd255);
        repeat (6) tickPulse();
        @(negedge clk);
        check("overrun saturates", {24'd0, overrunCount}, 32'd255);
        @(posedge clk); #1 bfDone = 1'b0;
        repeat (2) @(negedge clk);
        check("release idle", {31'd0, busy}, 32'd0);

        // Mid-frame reset in WAIT.
        @(posedge clk); #1 frameTick = 1'b1;
        @(posedge clk); #1 frameTick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("in WAIT before reset", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        check("async reset strobes", {26'd0, bfStart, bfAck, hitUnit, hitEnemy, moveEn, busy}, 32'd0);
        check("async reset counters", {frameCount, overrunCount, 7'd0, timeoutErr}, 32'd0);
        check("async reset holds", {4'd0, moveFriendlyLimit, moveEnemyLimit, hitUnitSel}, 32'd0);
        check("async reset enemy sel", {27'd0, hitEnemySel}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        expFrames = 0;
        runFrame(9'd1, 9'd2, 5'd1, 5'd2, 1, 0, 0);
        runFrame(9'd3, 9'd4, 5'd3, 5'd4, 1, 0, 0);
        runFrame(9'd5, 9'd6, 5'd5, 5'd6, 1, 0, 0);
        runFrame(9'd7, 9'd8, 5'h17, 5'd8, 2, 1, 0);
        check("timeoutErr cleared", {31'd0, timeoutErr}, 32'd0);

        repeat (3) @(posedge clk);
        check("hit queue drained", hitQ.size(), 32'd0);
        check("move queue drained", moveQ.size(), 32'd0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", checks);
        $fatal(1, "watchdog");
    end
endmodule
